// File: rtl/piezo_tone_sequencer_if.sv
// Request/tone bundle between the keypad/readback logic and the piezo tone sequencer.
// The requester drives start/key requests; the sequencer returns tone enables and status.
interface piezo_tone_sequencer_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    start;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    key_valid;
    logic [3:0]              key_digit;
    logic [9:0]              tone_en;
    logic                    busy;
    logic                    done;

    modport master (
        output start, digits, key_valid, key_digit,
        input  tone_en, busy, done
    );

    modport slave (
        input  start, digits, key_valid, key_digit,
        output tone_en, busy, done
    );
endinterface

// File: rtl/piezo_tone_sequencer.sv
// Plays a latched BCD string as timed notes with gaps, or a single key-click beep,
// onto a one-hot ten-tone piezo enable bus.
module piezo_tone_sequencer #(
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    piezo_tone_sequencer_if.slave       bus
);
    localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W      = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_NOTE = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [DIG_W-1:0]   digits_q,  digits_d;
    logic [3:0]         key_q,     key_d;
    logic [9:0]         tone_en_q, tone_en_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // Values 10..15 are rests: silent slot, same timing as a note.
    function automatic logic [9:0] tone_map(input logic [3:0] v);
        logic [9:0] t;
        if (v < 4'd10) begin
            t = 10'd1 << v;
        end else begin
            t = 10'd0;
        end
        return t;
    endfunction

    // Index 0 selects the most-significant nibble.
    function automatic logic [3:0] nibble_at(input logic [DIG_W-1:0] d, input logic [IDX_W-1:0] i);
        logic [DIG_W-1:0] s;
        s = d << {i, 2'b00};
        return s[DIG_W-1 -: 4];
    endfunction

    // State register and sequencing datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            digits_q <= {DIG_W{1'b0}};
            key_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            key_q    <= key_d;
        end
    end

    // Next-state logic: requests are only looked at in IDLE, start beats key_valid.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        digits_d = digits_q;
        key_d    = key_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_NOTE;
                    digits_d = bus.digits;
                    idx_d    = {IDX_W{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                end else if (bus.key_valid) begin
                    state_d = ST_KEY;
                    key_d   = bus.key_digit;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY: begin
                if (cnt_q == NOTE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_NOTE: begin
                if (cnt_q == NOTE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_NOTE;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        tone_en_d = 10'd0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            ST_NOTE: begin
                tone_en_d = tone_map(nibble_at(digits_d, idx_d));
                busy_d    = 1'b1;
            end
            ST_KEY: begin
                tone_en_d = tone_map(key_d);
                busy_d    = 1'b1;
            end
            ST_GAP: begin
                busy_d = 1'b1;
            end
            ST_IDLE: begin
                done_d = (state_q == ST_GAP);
            end
            default: begin
                tone_en_d = 10'd0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_en_q <= 10'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tone_en = tone_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_piezo_tone_sequencer.sv
// Randomized and directed bench for piezo_tone_sequencer against a per-cycle
// expected-output trace built from the playback rules.
module tb_piezo_tone_sequencer;
    localparam int NOTE = 4;
    localparam int GAP  = 2;
    localparam int ND   = 4;

    logic clk;
    logic rst;

    piezo_tone_sequencer_if #(.NUM_DIGITS(ND)) bus ();

    piezo_tone_sequencer #(
        .NOTE_CYCLES (NOTE),
        .GAP_CYCLES  (GAP),
        .NUM_DIGITS  (ND)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] tone;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_seen;
    int   done_seen;
    int   key2_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] tone_of(input logic [3:0] v);
        if (v <= 4'd9) return 10'd1 << v;
        else return 10'd0;
    endfunction

    // A full sequence: each digit sounds NOTE cycles then GAP silent cycles,
    // followed by one idle cycle carrying done.
    task automatic push_seq(input logic [15:0] d);
        logic [3:0] nib;
        for (int i = 0; i < ND; i++) begin
            nib = d[15 - 4*i -: 4];
            for (int n = 0; n < NOTE; n++) exp_q.push_back('{tone: tone_of(nib), busy: 1'b1, done: 1'b0});
            for (int g = 0; g < GAP; g++)  exp_q.push_back('{tone: 10'd0, busy: 1'b1, done: 1'b0});
        end
        exp_q.push_back('{tone: 10'd0, busy: 1'b0, done: 1'b1});
    endtask

    task automatic push_key(input logic [3:0] k);
        for (int n = 0; n < NOTE; n++) exp_q.push_back('{tone: tone_of(k), busy: 1'b1, done: 1'b0});
    endtask

    // One clock: model reacts to inputs at the edge, DUT compared 1 time unit later.
    task automatic cycle();
        if (!cur.busy) begin
            if (bus.start) push_seq(bus.digits);
            else if (bus.key_valid) push_key(bus.key_digit);
        end
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'(12'd0);
        @(posedge clk);
        #1;
        check_val("tone", 32'(bus.tone_en), 32'(cur.tone));
        check_val("busy", 32'(bus.busy), 32'(cur.busy));
        check_val("done", 32'(bus.done), 32'(cur.done));
        check_val("onehot", 32'($countones(bus.tone_en) <= 1), 32'd1);
        if (bus.busy) busy_seen++;
        if (bus.done) done_seen++;
        if (bus.tone_en == 10'h004) key2_seen++;
    endtask

    task automatic clear_req();
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
    endtask

    task automatic clear_stats();
        busy_seen = 0;
        done_seen = 0;
        key2_seen = 0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.digits    = 16'h0000;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        cur           = exp_t'(12'd0);
        clear_stats();
        #2 rst = 1'b0;
        #1;
        check_val("rst_tone", 32'(bus.tone_en), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_idle(3);

        // Plain sequence 1234.
        clear_stats();
        bus.start = 1'b1; bus.digits = 16'h1234;
        cycle();
        clear_req();
        run_idle(30);
        check_val("seq1234_busy_len", 32'(busy_seen), 32'd24);
        check_val("seq1234_done_cnt", 32'(done_seen), 32'd1);

        // Sequence with 9, 0 and a rest.
        clear_stats();
        bus.start = 1'b1; bus.digits = 16'h90A0;
        cycle();
        clear_req();
        run_idle(30);
        check_val("seq90A0_busy_len", 32'(busy_seen), 32'd24);

        // Key-click beep.
        clear_stats();
        bus.key_valid = 1'b1; bus.key_digit = 4'd7;
        cycle();
        clear_req();
        run_idle(8);
        check_val("key7_busy_len", 32'(busy_seen), 32'd4);
        check_val("key7_done_cnt", 32'(done_seen), 32'd0);

        // start wins over a simultaneous key.
        clear_stats();
        bus.start = 1'b1; bus.digits = 16'h5555;
        bus.key_valid = 1'b1; bus.key_digit = 4'd2;
        cycle();
        clear_req();
        run_idle(30);
        check_val("both_busy_len", 32'(busy_seen), 32'd24);
        check_val("both_key_tone", 32'(key2_seen), 32'd0);

        // Requests while busy are ignored.
        clear_stats();
        bus.start = 1'b1; bus.digits = 16'h1234;
        cycle();
        clear_req();
        run_idle(5);
        bus.start = 1'b1; bus.digits = 16'h8888;
        bus.key_valid = 1'b1; bus.key_digit = 4'd3;
        run_idle(3);
        clear_req();
        run_idle(25);
        check_val("busyign_busy_len", 32'(busy_seen), 32'd24);
        check_val("busyign_done_cnt", 32'(done_seen), 32'd1);

        // Re-entry on the done cycle.
        clear_stats();
        bus.start = 1'b1; bus.digits = 16'h1111;
        cycle();
        clear_req();
        for (int i = 0; i < 40 && !cur.done; i++) cycle();
        check_val("reentry_at_done", 32'(bus.done), 32'd1);
        bus.start = 1'b1; bus.digits = 16'h6789;
        cycle();
        clear_req();
        check_val("reentry_busy", 32'(bus.busy), 32'd1);
        run_idle(30);
        check_val("reentry_done_cnt", 32'(done_seen), 32'd2);
        check_val("reentry_busy_len", 32'(busy_seen), 32'd48);

        // Randomized requests.
        for (int i = 0; i < 1500; i++) begin
            bus.start     = ($urandom_range(0, 15) == 0);
            bus.digits    = 16'($urandom);
            bus.key_valid = ($urandom_range(0, 11) == 0);
            bus.key_digit = 4'($urandom_range(0, 9));
            cycle();
        end
        clear_req();
        run_idle(30);

        // Asynchronous reset in the middle of the first note.
        bus.start = 1'b1; bus.digits = 16'h1234;
        cycle();
        clear_req();
        cycle();
        #2 rst = 1'b0;
        #1;
        check_val("midrst_tone", 32'(bus.tone_en), 32'd0);
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        cur = exp_t'(12'd0);
        @(posedge clk);
        #1;
        check_val("inrst_tone", 32'(bus.tone_en), 32'd0);
        #2 rst = 1'b1;
        clear_stats();
        run_idle(10);
        check_val("postrst_busy_len", 32'(busy_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
